// File: rtl/dcache_pkg.sv
// Shared types and line geometry for the direct-mapped data cache controller.
package dcache_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      BUSY = 2'd2,
      FILL = 2'd3
   } state_t;

   localparam int LINEW          = 256;
   localparam int WORDS_PER_LINE = 8;
   localparam int OFFSET_LSB     = 2;
   localparam int INDEX_LSB      = 5;

   // Word 0 sits in the MSBs of the line.
   function automatic int word_lsb(input logic [2:0] offset);
      return LINEW - 32 * (int'(offset) + 1);
   endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag/valid/dirty/data storage: combinational lookup, word write, line fill.
module dcache_array
   import dcache_pkg::*;
#(
   parameter  int NLINES = 8,
   localparam int IDXW   = $clog2(NLINES),
   localparam int TAGW   = 32 - INDEX_LSB - IDXW
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [IDXW-1:0]  i_index,
   input  logic [TAGW-1:0]  i_tag,
   input  logic [2:0]       i_offset,
   input  logic             i_word_we,
   input  logic [31:0]      i_word_wd,
   input  logic             i_fill,
   input  logic [LINEW-1:0] i_fill_data,
   output logic             o_hit,
   output logic             o_valid,
   output logic             o_dirty,
   output logic [TAGW-1:0]  o_tag,
   output logic [LINEW-1:0] o_line,
   output logic [31:0]      o_word
);

   logic             r_valid [NLINES];
   logic             r_dirty [NLINES];
   logic [TAGW-1:0]  r_tag   [NLINES];
   logic [LINEW-1:0] r_data  [NLINES];

   assign o_valid = r_valid[i_index];
   assign o_dirty = r_dirty[i_index];
   assign o_tag   = r_tag[i_index];
   assign o_line  = r_data[i_index];
   assign o_hit   = r_valid[i_index] & (r_tag[i_index] == i_tag);
   assign o_word  = r_data[i_index][word_lsb(i_offset) +: 32];

   // Only the control bits are cleared; tag/data are don't-care while invalid.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NLINES; i++) begin
            r_valid[i] <= 1'b0;
            r_dirty[i] <= 1'b0;
         end
      end else if (i_fill) begin
         r_valid[i_index] <= 1'b1;
         r_dirty[i_index] <= 1'b0;
         r_tag[i_index]   <= i_tag;
         r_data[i_index]  <= i_fill_data;
      end else if (i_word_we) begin
         r_data[i_index][word_lsb(i_offset) +: 32] <= i_word_wd;
         r_dirty[i_index]                          <= 1'b1;
      end
   end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate cache controller; a dirty victim
// writeback and the refill travel in a single memory block transaction.
module dcache_ctrl
   import dcache_pkg::*;
#(
   parameter int NLINES = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cpu_re,
   input  logic             cpu_we,
   input  logic [31:0]      cpu_addr,
   input  logic [31:0]      cpu_wd,
   output logic [31:0]      cpu_rd,
   output logic             cpu_stall,
   output logic             mem_blockread,
   output logic             mem_blockwrite,
   output logic [31:0]      mem_readaddr,
   output logic [31:0]      mem_writeaddr,
   output logic [LINEW-1:0] mem_writeblock,
   input  logic [LINEW-1:0] mem_readblock,
   input  logic             mem_ready
);

   // state | meaning
   // IDLE  | serve hits; on a miss latch victim/refill info, wait for mem_ready
   // REQ   | one-cycle blockread strobe (blockwrite if the victim is dirty)
   // BUSY  | memory working, wait for mem_ready
   // FILL  | write refill line into the array, then replay the request

   localparam int IDXW = $clog2(NLINES);
   localparam int TAGW = 32 - INDEX_LSB - IDXW;

   state_t           r_state;
   logic [IDXW-1:0]  w_index;
   logic [TAGW-1:0]  w_tag;
   logic [TAGW-1:0]  w_vtag;
   logic [2:0]       w_offset;
   logic             w_req;
   logic             w_hit;
   logic             w_valid;
   logic             w_dirty;
   logic             w_word_we;
   logic             w_fill;
   logic [LINEW-1:0] w_line;
   logic [31:0]      w_word;
   logic             w_unused;

   assign w_index   = cpu_addr[INDEX_LSB +: IDXW];
   assign w_tag     = cpu_addr[31 -: TAGW];
   assign w_offset  = cpu_addr[OFFSET_LSB +: 3];
   assign w_unused  = &{1'b0, cpu_addr[1:0]};
   assign w_req     = cpu_re | cpu_we;
   assign w_word_we = (r_state == IDLE) & cpu_we & w_hit;
   assign w_fill    = (r_state == FILL);
   assign cpu_stall = (r_state != IDLE) | (w_req & ~w_hit);
   assign cpu_rd    = w_word;

   dcache_array #(
      .NLINES (NLINES)
   ) u_array (
      .clk         (clk),
      .reset       (reset),
      .i_index     (w_index),
      .i_tag       (w_tag),
      .i_offset    (w_offset),
      .i_word_we   (w_word_we),
      .i_word_wd   (cpu_wd),
      .i_fill      (w_fill),
      .i_fill_data (mem_readblock),
      .o_hit       (w_hit),
      .o_valid     (w_valid),
      .o_dirty     (w_dirty),
      .o_tag       (w_vtag),
      .o_line      (w_line),
      .o_word      (w_word)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state        <= IDLE;
         mem_blockread  <= 1'b0;
         mem_blockwrite <= 1'b0;
         mem_readaddr   <= '0;
         mem_writeaddr  <= '0;
         mem_writeblock <= '0;
      end else begin
         mem_blockread  <= 1'b0;
         mem_blockwrite <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_req & ~w_hit) begin
                  mem_readaddr   <= {{INDEX_LSB{1'b0}}, cpu_addr[31:INDEX_LSB]};
                  mem_writeaddr  <= {{INDEX_LSB{1'b0}}, w_vtag, w_index};
                  mem_writeblock <= w_line;
                  // mem_ready gate also covers a memory still busy after a reset
                  if (mem_ready) begin
                     r_state        <= REQ;
                     mem_blockread  <= 1'b1;
                     mem_blockwrite <= w_valid & w_dirty;
                  end
               end
            end
            REQ:  r_state <= BUSY;
            BUSY: if (mem_ready) r_state <= FILL;
            FILL: r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Randomized bench for dcache_ctrl against a coherent word-memory model.
module tb_dcache_ctrl;

   logic         clk = 1'b0;
   logic         reset;
   logic         cpu_re, cpu_we;
   logic [31:0]  cpu_addr, cpu_wd, cpu_rd;
   logic         cpu_stall;
   logic         mem_blockread, mem_blockwrite;
   logic [31:0]  mem_readaddr, mem_writeaddr;
   logic [255:0] mem_writeblock, mem_readblock;
   logic         mem_ready = 1'b1;

   always #5 clk = ~clk;

   dcache_ctrl #(.NLINES(8)) dut (
      .clk            (clk),
      .reset          (reset),
      .cpu_re         (cpu_re),
      .cpu_we         (cpu_we),
      .cpu_addr       (cpu_addr),
      .cpu_wd         (cpu_wd),
      .cpu_rd         (cpu_rd),
      .cpu_stall      (cpu_stall),
      .mem_blockread  (mem_blockread),
      .mem_blockwrite (mem_blockwrite),
      .mem_readaddr   (mem_readaddr),
      .mem_writeaddr  (mem_writeaddr),
      .mem_writeblock (mem_writeblock),
      .mem_readblock  (mem_readblock),
      .mem_ready      (mem_ready)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Block memory (128 blocks) and the coherent truth: last value written per word.
   logic [255:0] mem_blk  [128];
   logic [31:0]  ref_word [1024];
   // Cache directory model: what line each index holds.
   logic         m_valid [8];
   logic         m_dirty [8];
   int           m_tag   [8];

   int           txn_cnt = 0;
   logic         t_bw;
   logic [31:0]  t_raddr, t_waddr;
   logic [255:0] t_wblock;
   int           mem_cnt = 0;
   logic         prev_br = 1'b0;

   assign mem_readblock = mem_blk[mem_readaddr[6:0]];

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [255:0] ref_block(input int b);
      logic [255:0] blk;
      blk = '0;
      for (int w = 0; w < 8; w++) blk[255-32*w -: 32] = ref_word[b*8+w];
      return blk;
   endfunction

   // Memory: accepts a strobe while idle, busy for 5 counts, writeback applied on accept.
   always @(negedge clk) begin
      if (mem_ready) begin
         if (mem_blockread) begin
            txn_cnt++;
            t_bw     = mem_blockwrite;
            t_raddr  = mem_readaddr;
            t_waddr  = mem_writeaddr;
            t_wblock = mem_writeblock;
            if (mem_blockwrite) mem_blk[mem_writeaddr[6:0]] = mem_writeblock;
            mem_ready = 1'b0;
            mem_cnt   = 5;
         end
      end else begin
         mem_cnt--;
         if (mem_cnt == 0) mem_ready = 1'b1;
      end
   end

   // Per-cycle protocol checks on the strobe.
   always @(negedge clk) begin
      #2;
      if (mem_blockread) begin
         chk("br_with_stall", cpu_stall, 1'b1);
         chk("br_single_cycle", prev_br, 1'b0);
      end
      prev_br = mem_blockread;
   end

   task automatic do_req(input logic re, input logic we, input logic [31:0] addr,
                         input logic [31:0] wd, output logic [31:0] rd, output int stalls);
      int           blk, idx, tg, wi, victim, t0;
      logic         miss, exp_bw;
      logic [31:0]  exp_rd;
      logic [255:0] exp_wb;
      blk    = int'(addr[11:5]);
      idx    = blk % 8;
      tg     = blk / 8;
      wi     = int'(addr[11:2]);
      miss   = !(m_valid[idx] && m_tag[idx] == tg);
      exp_bw = miss && m_valid[idx] && m_dirty[idx];
      victim = m_tag[idx] * 8 + idx;
      exp_wb = ref_block(victim);
      exp_rd = ref_word[wi];
      t0     = txn_cnt;
      @(negedge clk);
      cpu_re = re; cpu_we = we; cpu_addr = addr; cpu_wd = wd;
      #1;
      stalls = 0;
      while (cpu_stall && stalls < 40) begin
         stalls++;
         @(negedge clk); #1;
      end
      rd = cpu_rd;
      chk("stall_cycles", stalls, miss ? 8 : 0);
      chk("txn_count", txn_cnt - t0, miss ? 1 : 0);
      if (re) chk("cpu_rd", rd, exp_rd);
      if (miss) begin
         chk("readaddr", t_raddr, blk);
         chk("blockwrite", t_bw, exp_bw);
         if (exp_bw) begin
            chk("writeaddr", t_waddr, victim);
            chk("writeblock", t_wblock, exp_wb);
         end
         m_valid[idx] = 1'b1;
         m_tag[idx]   = tg;
         m_dirty[idx] = 1'b0;
      end
      if (we) begin
         ref_word[wi] = wd;
         m_dirty[idx] = 1'b1;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] rd;
      int          stalls, k, t0, op;
      logic [31:0] a;

      for (int b = 0; b < 128; b++) begin
         for (int w = 0; w < 8; w++) begin
            logic [31:0] v;
            v = (b == 1) ? {8{4'(w + 1)}} : $urandom;
            mem_blk[b][255-32*w -: 32] = v;
            ref_word[b*8+w] = v;
         end
      end
      for (int i = 0; i < 8; i++) begin
         m_valid[i] = 1'b0; m_dirty[i] = 1'b0; m_tag[i] = 0;
      end

      reset = 1'b1; cpu_re = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wd = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst_stall", cpu_stall, 1'b0);
      chk("rst_blockread", mem_blockread, 1'b0);
      chk("rst_blockwrite", mem_blockwrite, 1'b0);
      chk("rst_readaddr", mem_readaddr, 32'h0);
      chk("rst_writeaddr", mem_writeaddr, 32'h0);
      chk("rst_writeblock", mem_writeblock, 256'h0);

      do_req(1'b1, 1'b0, 32'h24, 32'h0, rd, stalls);
      chk("cold_rd_lit", rd, 32'h22222222);
      chk("cold_stall_lit", stalls, 8);
      chk("cold_raddr_lit", t_raddr, 32'd1);
      chk("cold_bw_lit", t_bw, 1'b0);

      do_req(1'b1, 1'b0, 32'h20, 32'h0, rd, stalls);
      chk("hit_rd_lit", rd, 32'h11111111);
      chk("hit_stall_lit", stalls, 0);

      do_req(1'b0, 1'b1, 32'h24, 32'hDEADBEEF, rd, stalls);
      t0 = txn_cnt;
      do_req(1'b1, 1'b0, 32'h124, 32'h0, rd, stalls);
      chk("evict_txn_lit", txn_cnt - t0, 1);
      chk("evict_bw_lit", t_bw, 1'b1);
      chk("evict_waddr_lit", t_waddr, 32'd1);
      chk("evict_raddr_lit", t_raddr, 32'd9);
      chk("evict_wword_lit", t_wblock[223:192], 32'hDEADBEEF);

      do_req(1'b1, 1'b0, 32'h24, 32'h0, rd, stalls);
      chk("reload_rd_lit", rd, 32'hDEADBEEF);
      chk("reload_stall_lit", stalls, 8);

      do_req(1'b0, 1'b1, 32'h48, 32'hCAFEF00D, rd, stalls);
      chk("wmiss_stall_lit", stalls, 8);
      chk("wmiss_raddr_lit", t_raddr, 32'd2);
      do_req(1'b1, 1'b0, 32'h48, 32'h0, rd, stalls);
      chk("wmiss_rd_lit", rd, 32'hCAFEF00D);

      do_req(1'b1, 1'b1, 32'h48, 32'h12345678, rd, stalls);
      chk("rw_old_rd_lit", rd, 32'hCAFEF00D);
      chk("rw_stall_lit", stalls, 0);
      do_req(1'b1, 1'b0, 32'h48, 32'h0, rd, stalls);
      chk("rw_new_rd_lit", rd, 32'h12345678);
      do_req(1'b1, 1'b0, 32'h148, 32'h0, rd, stalls);
      chk("rw_dirty_bw_lit", t_bw, 1'b1);
      chk("rw_dirty_word_lit", t_wblock[191:160], 32'h12345678);

      // Reset while the memory is mid-transaction.
      @(negedge clk);
      cpu_re = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h300;
      #1;
      k = 0;
      while (!mem_blockread && k < 20) begin
         @(negedge clk); #1; k++;
      end
      chk("rstb_saw_req", mem_blockread, 1'b1);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rstb_br_low", mem_blockread, 1'b0);
      chk("rstb_mem_busy", mem_ready, 1'b0);
      chk("rstb_stall", cpu_stall, 1'b1);
      for (int i = 0; i < 8; i++) begin
         m_valid[i] = 1'b0; m_dirty[i] = 1'b0;
      end
      for (int b = 0; b < 128; b++)
         for (int w = 0; w < 8; w++) ref_word[b*8+w] = mem_blk[b][255-32*w -: 32];
      k = 0;
      while (!mem_ready && k < 20) begin
         chk("rstb_gate", mem_blockread, 1'b0);
         @(negedge clk); #1; k++;
      end
      t0 = txn_cnt;
      stalls = 0;
      while (cpu_stall && stalls < 40) begin
         stalls++;
         @(negedge clk); #1;
      end
      chk("rstb_reissue_stall", stalls, 8);
      chk("rstb_reissue_txn", txn_cnt - t0, 1);
      chk("rstb_reissue_raddr", t_raddr, 32'd24);
      chk("rstb_reissue_bw", t_bw, 1'b0);
      chk("rstb_reissue_rd", cpu_rd, ref_word[32'h300 >> 2]);
      m_valid[0] = 1'b1; m_tag[0] = 3; m_dirty[0] = 1'b0;

      do_req(1'b1, 1'b0, 32'h20, 32'h0, rd, stalls);
      chk("rstb_invalidated_lit", stalls, 8);

      for (int n = 0; n < 400; n++) begin
         op = $urandom_range(0, 9);
         a  = {22'b0, 10'($urandom_range(0, 1023))};
         if (op == 0) begin
            t0 = txn_cnt;
            @(negedge clk);
            cpu_re = 1'b0; cpu_we = 1'b0; cpu_addr = $urandom; cpu_wd = $urandom;
            #1;
            chk("idle_stall", cpu_stall, 1'b0);
            @(negedge clk); #1;
            chk("idle_no_txn", txn_cnt - t0, 0);
         end else if (op <= 5) begin
            do_req(1'b1, 1'b0, a, $urandom, rd, stalls);
         end else if (op <= 8) begin
            do_req(1'b0, 1'b1, a, $urandom, rd, stalls);
         end else begin
            do_req(1'b1, 1'b1, a, $urandom, rd, stalls);
         end
      end

      @(negedge clk);
      cpu_re = 1'b0; cpu_we = 1'b0;
      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
